// File: rtl/instruction_sequencer_if.sv
// Sequencer-side bundle: instruction/ack/flag inputs and decoded control strobes.
// Sequencer uses the master modport; the ROM/RAM/ALU environment uses slave.
interface instruction_sequencer_if #(
  parameter int OP_BITS         = 4,
  parameter int MODE_WIDTH      = 4,
  parameter int OPERAND_WIDTH   = 8,
  parameter int ADDR_MODE_WIDTH = 2
) ();
  localparam int ROM_WIDTH = OP_BITS + MODE_WIDTH + OPERAND_WIDTH;

  logic [ROM_WIDTH-1:0]       rom_in;
  logic                       rom_valid;
  logic                       mem_ready;
  logic                       zero_flag;
  logic                       sign_flag;
  logic                       resume;
  logic [OPERAND_WIDTH-1:0]   operand_out;
  logic [ADDR_MODE_WIDTH-1:0] addr_mode_out;
  logic [OP_BITS-1:0]         alu_op_out;
  logic                       fetch_ena;
  logic                       execute_ena;
  logic                       write_ram_ena;
  logic                       write_reg_ena;
  logic                       jump_ena;
  logic                       halted;
  logic                       illegal;

  modport master (
    input  rom_in, rom_valid, mem_ready, zero_flag, sign_flag, resume,
    output operand_out, addr_mode_out, alu_op_out, fetch_ena, execute_ena,
           write_ram_ena, write_reg_ena, jump_ena, halted, illegal
  );

  modport slave (
    output rom_in, rom_valid, mem_ready, zero_flag, sign_flag, resume,
    input  operand_out, addr_mode_out, alu_op_out, fetch_ena, execute_ena,
           write_ram_ena, write_reg_ena, jump_ena, halted, illegal
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/EXECUTE/EXECUTE_2/WRITE_BACK/HALT FSM over a latched IR.
// Outputs are combinational from state+IR; any DIR/INDIR access stalls in place until mem_ready.
module instruction_sequencer #(
  parameter int OP_BITS         = 4,
  parameter int MODE_WIDTH      = 4,
  parameter int OPERAND_WIDTH   = 8,
  parameter int ADDR_MODE_WIDTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  instruction_sequencer_if.master bus
);
  localparam int ROM_WIDTH = OP_BITS + MODE_WIDTH + OPERAND_WIDTH;
  localparam int HALF      = OPERAND_WIDTH / 2;

  localparam logic [2:0] S_FETCH      = 3'd0;
  localparam logic [2:0] S_EXECUTE    = 3'd1;
  localparam logic [2:0] S_EXECUTE_2  = 3'd2;
  localparam logic [2:0] S_WRITE_BACK = 3'd3;
  localparam logic [2:0] S_HALT       = 3'd4;

  localparam logic [ADDR_MODE_WIDTH-1:0] AM_IMME  = ADDR_MODE_WIDTH'(0);
  localparam logic [ADDR_MODE_WIDTH-1:0] AM_DIR   = ADDR_MODE_WIDTH'(1);
  localparam logic [ADDR_MODE_WIDTH-1:0] AM_INDIR = ADDR_MODE_WIDTH'(2);
  localparam logic [ADDR_MODE_WIDTH-1:0] AM_REG   = ADDR_MODE_WIDTH'(3);

  localparam logic [MODE_WIDTH-1:0] M_NOP   = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] M_IMM   = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] M_LOAD  = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0] M_STORE = MODE_WIDTH'(3);
  localparam logic [MODE_WIDTH-1:0] M_R2R   = MODE_WIDTH'(4);
  localparam logic [MODE_WIDTH-1:0] M_R2M   = MODE_WIDTH'(5);
  localparam logic [MODE_WIDTH-1:0] M_M2R   = MODE_WIDTH'(6);
  localparam logic [MODE_WIDTH-1:0] M_M2M   = MODE_WIDTH'(7);
  localparam logic [MODE_WIDTH-1:0] M_HALT  = MODE_WIDTH'(8);

  localparam logic [OP_BITS-1:0] OP_PASS = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_ADD  = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_SUB  = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_AND  = OP_BITS'(7);
  localparam logic [OP_BITS-1:0] OP_OR   = OP_BITS'(8);
  localparam logic [OP_BITS-1:0] OP_XOR  = OP_BITS'(9);
  localparam logic [OP_BITS-1:0] OP_JA   = OP_BITS'(11);
  localparam logic [OP_BITS-1:0] OP_JZ   = OP_BITS'(12);
  localparam logic [OP_BITS-1:0] OP_JS   = OP_BITS'(13);
  localparam logic [OP_BITS-1:0] OP_JNZ  = OP_BITS'(14);
  localparam logic [OP_BITS-1:0] OP_JNS  = OP_BITS'(15);

  logic [2:0]                 state, state_nxt;
  logic [ROM_WIDTH-1:0]       ir;
  logic                       illegal_q;

  logic [OP_BITS-1:0]         opcode;
  logic [MODE_WIDTH-1:0]      mode;
  logic [OPERAND_WIDTH-1:0]   operand, src_field, dst_field;
  logic [ADDR_MODE_WIDTH-1:0] src_mode, dst_mode;
  logic                       two_op, mode_illegal, math2, is_jump, jump_cond, mem_wait;

  logic [OPERAND_WIDTH-1:0]   operand_o;
  logic [ADDR_MODE_WIDTH-1:0] addr_mode_o;
  logic [OP_BITS-1:0]         alu_op_o;
  logic                       fetch_o, exec_o, wram_o, wreg_o, jump_o, halted_o;

  assign opcode    = ir[ROM_WIDTH-1 -: OP_BITS];
  assign mode      = ir[OPERAND_WIDTH +: MODE_WIDTH];
  assign operand   = ir[OPERAND_WIDTH-1:0];
  assign src_field = OPERAND_WIDTH'(operand[OPERAND_WIDTH-1:HALF]);
  assign dst_field = OPERAND_WIDTH'(operand[HALF-1:0]);

  assign math2   = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
                   (opcode == OP_OR)  || (opcode == OP_XOR);
  assign is_jump = (opcode >= OP_JA);

  always_comb begin
    src_mode     = AM_IMME;
    dst_mode     = AM_IMME;
    two_op       = 1'b0;
    mode_illegal = 1'b0;
    case (mode)
      M_NOP, M_IMM, M_HALT: begin end
      M_LOAD, M_STORE:      src_mode = AM_DIR;
      M_R2R: begin src_mode = AM_REG;   dst_mode = AM_REG;   two_op = 1'b1; end
      M_R2M: begin src_mode = AM_REG;   dst_mode = AM_INDIR; two_op = 1'b1; end
      M_M2R: begin src_mode = AM_INDIR; dst_mode = AM_REG;   two_op = 1'b1; end
      M_M2M: begin src_mode = AM_INDIR; dst_mode = AM_INDIR; two_op = 1'b1; end
      default: mode_illegal = 1'b1;
    endcase
  end

  always_comb begin
    jump_cond = 1'b0;
    case (opcode)
      OP_JA:   jump_cond = 1'b1;
      OP_JZ:   jump_cond = bus.zero_flag;
      OP_JS:   jump_cond = bus.sign_flag;
      OP_JNZ:  jump_cond = !bus.zero_flag;
      OP_JNS:  jump_cond = !bus.sign_flag;
      default: jump_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    operand_o   = '0;
    addr_mode_o = AM_IMME;
    alu_op_o    = OP_PASS;
    fetch_o     = 1'b0;
    exec_o      = 1'b0;
    wram_o      = 1'b0;
    wreg_o      = 1'b0;
    jump_o      = 1'b0;
    halted_o    = 1'b0;
    mem_wait    = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_o = 1'b1;
        if (bus.rom_valid) state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        // First pass of a two-operand math op only moves the source, so the ALU passes it through.
        alu_op_o    = (math2 && mode != M_IMM) ? OP_PASS : opcode;
        operand_o   = two_op ? src_field : operand;
        addr_mode_o = src_mode;
        mem_wait    = ((src_mode == AM_DIR) || (src_mode == AM_INDIR)) && !bus.mem_ready;
        wram_o      = (mode == M_STORE);
        if (!mem_wait) begin
          exec_o = !((mode == M_NOP) || (mode == M_STORE) || (mode == M_HALT) ||
                     mode_illegal || is_jump);
          jump_o = is_jump && jump_cond;
          if (mode == M_HALT)                         state_nxt = S_HALT;
          else if (math2 && mode != M_IMM && two_op)  state_nxt = S_EXECUTE_2;
          else if (two_op && !jump_o)                 state_nxt = S_WRITE_BACK;
          else                                        state_nxt = S_FETCH;
        end
      end
      S_EXECUTE_2: begin
        alu_op_o    = opcode;
        operand_o   = dst_field;
        addr_mode_o = dst_mode;
        mem_wait    = (dst_mode == AM_INDIR) && !bus.mem_ready;
        if (!mem_wait) begin
          exec_o    = 1'b1;
          state_nxt = S_WRITE_BACK;
        end
      end
      S_WRITE_BACK: begin
        operand_o   = dst_field;
        addr_mode_o = dst_mode;
        wreg_o      = (dst_mode == AM_REG);
        wram_o      = (dst_mode == AM_INDIR);
        mem_wait    = (dst_mode == AM_INDIR) && !bus.mem_ready;
        if (!mem_wait) state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted_o = 1'b1;
        if (bus.resume) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && bus.rom_valid) ir <= bus.rom_in;
      if (state == S_EXECUTE && mode_illegal) illegal_q <= 1'b1;
    end
  end

  assign bus.operand_out   = operand_o;
  assign bus.addr_mode_out = addr_mode_o;
  assign bus.alu_op_out    = alu_op_o;
  assign bus.fetch_ena     = fetch_o;
  assign bus.execute_ena   = exec_o;
  assign bus.write_ram_ena = wram_o;
  assign bus.write_reg_ena = wreg_o;
  assign bus.jump_ena      = jump_o;
  assign bus.halted        = halted_o;
  assign bus.illegal       = illegal_q;
endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameters (name, default, meaning); ROM_WIDTH is derived, not overridable:
  OP_BITS, 4, opcode width
  MODE_WIDTH, 4, mode width
  OPERAND_WIDTH, 8, operand width, SHALL be even
  ADDR_MODE_WIDTH, 2, addressing-mode width
  ROM_WIDTH, OP_BITS+MODE_WIDTH+OPERAND_WIDTH, instruction width (derived)
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  rom_in  in  ROM_WIDTH  instruction word, {opcode, mode, operand} MSB-first
  rom_valid  in  1  rom_in valid this cycle
  mem_ready  in  1  RAM access completes this cycle
  zero_flag  in  1  ALU zero flag
  sign_flag  in  1  ALU sign flag
  resume  in  1  leave HALT
  operand_out  out  OPERAND_WIDTH  operand or src/dst field
  addr_mode_out  out  ADDR_MODE_WIDTH  IMME=00, DIR=01, INDIR=10, REG=11
  alu_op_out  out  OP_BITS  ALU opcode
  fetch_ena  out  1  fetch strobe
  execute_ena  out  1  ALU/accumulator update strobe
  write_ram_ena  out  1  RAM write request
  write_reg_ena  out  1  register-file write strobe
  jump_ena  out  1  PC load strobe
  halted  out  1  in HALT state
  illegal  out  1  sticky illegal-mode flag

Function
REQ-003 Opcodes: PASS 0, ADD 1, SUB 2, INC 3, DEC 4, RL 5, RR 6, AND 7, OR 8, XOR 9, NOT A, JA B, JZ C, JS D, JNZ E, JNS F.
REQ-004 Mode encoding and (src, dst) addressing: NOP 0 (00,00); IMM 1 (IMME,00); LOAD 2 (DIR,00); STORE 3 (DIR,00); R2R 4 (REG,REG); R2M 5 (REG,INDIR); M2R 6 (INDIR,REG); M2M 7 (INDIR,INDIR); HALT 8 (00,00); modes 9-F illegal.
REQ-005 Two-operand modes (4-7): src = operand upper half, dst = operand lower half.
REQ-006 Two-operand math = ADD, SUB, AND, OR, XOR.
REQ-007 Memory access = current addr_mode_out is DIR or INDIR.
REQ-008 States: FETCH, EXECUTE, EXECUTE_2, WRITE_BACK, HALT; state register reset to FETCH.
REQ-009 FETCH: fetch_ena=1; on rom_valid=1, latch rom_in into instruction register (IR) and go to EXECUTE; otherwise remain in FETCH.
REQ-010 All decoding SHALL use IR only; rom_in changes after the latch have no effect.
REQ-011 EXECUTE outputs: alu_op_out = PASS if (two-op math and mode != IMM), else opcode; operand_out = src if two-operand mode, else operand; addr_mode_out = src addressing mode.
REQ-012 EXECUTE, memory access with mem_ready=0: hold state and all outputs; execute_ena=0 and jump_ena=0 during the wait.
REQ-013 EXECUTE, STORE: write_ram_ena=1 in every EXECUTE cycle until mem_ready=1; execute_ena=0 throughout.
REQ-014 EXECUTE, completion cycle (non-memory access, or mem_ready=1): execute_ena=1 unless mode is NOP, STORE, HALT or illegal, or the opcode is a jump.
REQ-015 Jump condition from flags sampled in EXECUTE: JA=1, JZ=zero, JS=sign, JNZ=!zero, JNS=!sign. jump_ena=1 for exactly one cycle when the condition is true.
REQ-016 Transitions from EXECUTE completion:
  HALT mode -> HALT
  two-op math and mode != IMM and two-operand mode -> EXECUTE_2
  two-operand mode and no taken jump -> WRITE_BACK
  otherwise -> FETCH
REQ-017 EXECUTE_2: alu_op_out=opcode; operand_out=dst; addr_mode_out=dst mode. Waits on mem_ready per REQ-012; execute_ena=1 only in the completion cycle; then -> WRITE_BACK.
REQ-018 WRITE_BACK: operand_out=dst; addr_mode_out=dst mode; write_reg_ena=1 if dst mode is REG (single cycle, then -> FETCH). If dst mode is INDIR, write_ram_ena is held until mem_ready=1, then -> FETCH.
REQ-019 HALT: halted=1, all other outputs 0; resume=1 -> FETCH next cycle.
REQ-020 Illegal mode in EXECUTE: set illegal=1 (sticky until rst), treat as NOP, -> FETCH.
REQ-021 All outputs not named for a state SHALL be 0 in that state.

Reset
REQ-022 rst=1 forces state=FETCH, IR=0, illegal=0 immediately, in any state including mid-wait.
REQ-023 While rst=1: fetch_ena=1 and all other outputs 0.

Verification
REQ-024 rom_in=16'h1423 (ADD R2R), rom_valid=1 -> EXECUTE alu 0, op 2, mode 11, exe 1; EXECUTE_2 alu 1, op 3, exe 1; WRITE_BACK write_reg_ena=1, op 3; FETCH on 4th cycle.
REQ-025 16'h0205 (LOAD), mem_ready=0 for 2 cycles -> EXECUTE held 3 cycles with op 05, mode 01; execute_ena=1 only in the 3rd cycle.
REQ-026 16'hC040 (JZ): zero_flag=1 -> jump_ena=1 for 1 cycle, execute_ena=0; zero_flag=0 -> jump_ena=0; both return to FETCH.
REQ-027 16'h0800 -> halted=1 held for 10 cycles with resume=0; resume=1 -> FETCH, fetch_ena=1 next cycle.
REQ-028 rom_valid=0 for 3 cycles -> stays in FETCH; then 16'h0A00 -> illegal=1 and stays 1 across later instructions, execute_ena=0.
REQ-029 rst pulsed during EXECUTE_2 of 16'h1777 -> FETCH immediately, illegal=0, no write_ram_ena pulse.
